// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: shared definitions for the data-memory responder.
//   - dm_state_e   : responder FSM state encoding
//   - NumLanes / LaneWidth / WordWidth : byte-lane geometry of a memory word
//   - merge_bytes  : byte-enable merge of new store data into an old word
package dm_responder_pkg;

    typedef enum logic [1:0] {
        StClear,
        StIdle,
        StWait,
        StResp
    } dm_state_e;

    localparam int unsigned NumLanes  = 4;
    localparam int unsigned LaneWidth = 8;
    localparam int unsigned WordWidth = NumLanes * LaneWidth;

    // Lane i of the result comes from new_word when be[i] is set, else from old_word.
    function automatic logic [WordWidth-1:0] merge_bytes(
        input logic [WordWidth-1:0] old_word,
        input logic [WordWidth-1:0] new_word,
        input logic [NumLanes-1:0]  be
    );
        logic [WordWidth-1:0] res;
        res = old_word;
        for (int i = 0; i < NumLanes; i++) begin
            if (be[i]) begin
                res[i*LaneWidth +: LaneWidth] = new_word[i*LaneWidth +: LaneWidth];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_array.sv
// dm_array: word storage for dm_responder.
//   clk     : rising-edge clock
//   wr_en   : write strobe (single write port)
//   wr_idx  : word index to write
//   wr_data : word to write
//   rd_idx  : word index for the combinational read
//   rd_data : word at rd_idx
// No reset: contents are initialised by the responder's CLEAR sweep.
module dm_array
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned IDX_W       = 12
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [WordWidth-1:0] wr_data,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [WordWidth-1:0] rd_data
);

    logic [WordWidth-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder with a fixed request-to-response latency.
//   clk, reset            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (one outstanding request)
//   req_we/be/addr/wdata  : store flag, byte enables, byte address, store data
//   req_pc                : PC of the issuer, carried to the store trace
//   resp_valid/rdata/err  : one-cycle response strobe, load data, error flag
//   wr_trace_*            : one-cycle record of each committed store
//   busy                  : high whenever not IDLE
// After reset the array is swept to zero (CLEAR) before requests are accepted.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        wr_trace_valid,
    output logic [31:0] wr_trace_pc,
    output logic [31:0] wr_trace_addr,
    output logic [31:0] wr_trace_data,
    output logic        busy
);

    localparam int unsigned    IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]     LatM1   = 4'(LATENCY - 1);
    localparam logic [29:0]    DepthW  = 30'(DEPTH_WORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH_WORDS - 1);

    dm_state_e      state_q, state_d;
    logic [IdxW-1:0] clr_idx_q, clr_idx_d;
    logic [3:0]     cnt_q, cnt_d;

    // Latched request
    logic           we_q, we_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    pc_q, pc_d;

    // Registered outputs
    logic           resp_valid_q, resp_valid_d;
    logic [31:0]    resp_rdata_q, resp_rdata_d;
    logic           resp_err_q, resp_err_d;
    logic           tr_valid_q, tr_valid_d;
    logic [31:0]    tr_pc_q, tr_pc_d;
    logic [31:0]    tr_addr_q, tr_addr_d;
    logic [31:0]    tr_data_q, tr_data_d;

    logic           in_idle;
    logic           enter_resp;

    // With LATENCY==1 the response is formed on the accept edge itself, before the
    // request has been latched, so the active request is the live one in IDLE.
    logic           act_we;
    logic [3:0]     act_be;
    logic [31:0]    act_addr;
    logic [31:0]    act_wdata;
    logic [31:0]    act_pc;
    logic           act_err;
    logic [IdxW-1:0] act_idx;

    logic           arr_we;
    logic [IdxW-1:0] arr_widx;
    logic [31:0]    arr_wdata;
    logic [31:0]    rd_data;
    logic [31:0]    merged;

    assign in_idle   = (state_q == StIdle);
    assign act_we    = in_idle ? req_we    : we_q;
    assign act_be    = in_idle ? req_be    : be_q;
    assign act_addr  = in_idle ? req_addr  : addr_q;
    assign act_wdata = in_idle ? req_wdata : wdata_q;
    assign act_pc    = in_idle ? req_pc    : pc_q;
    assign act_err   = (act_addr[1:0] != 2'b00) || (act_addr[31:2] >= DepthW);
    assign act_idx   = act_addr[IdxW+1:2];
    assign merged    = merge_bytes(rd_data, act_wdata, act_be);

    assign enter_resp = (in_idle && req_valid && (LATENCY == 1)) ||
                        ((state_q == StWait) && (cnt_q == 4'd1));

    dm_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IdxW)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_we),
        .wr_idx  (arr_widx),
        .wr_data (arr_wdata),
        .rd_idx  (act_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pc_d         = pc_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        tr_valid_d   = 1'b0;
        tr_pc_d      = '0;
        tr_addr_d    = '0;
        tr_data_d    = '0;
        arr_we       = 1'b0;
        arr_widx     = act_idx;
        arr_wdata    = merged;

        unique case (state_q)
            StClear: begin
                arr_we    = 1'b1;
                arr_widx  = clr_idx_q;
                arr_wdata = '0;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LastIdx) begin
                    clr_idx_d = '0;
                    state_d   = StIdle;
                end
            end
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    be_d    = req_be;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    cnt_d   = LatM1;
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
        endcase

        // Response and store commit share the edge that enters RESP; enter_resp is
        // never true in CLEAR, so the single write port is never contended.
        if (enter_resp) begin
            resp_valid_d = 1'b1;
            resp_err_d   = act_err;
            resp_rdata_d = (act_err || act_we) ? 32'h0 : rd_data;
            if (act_we && !act_err) begin
                arr_we     = 1'b1;
                tr_valid_d = 1'b1;
                tr_pc_d    = act_pc;
                tr_addr_d  = {act_addr[31:2], 2'b00};
                tr_data_d  = merged;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StClear;
            clr_idx_q    <= '0;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pc_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            tr_valid_q   <= 1'b0;
            tr_pc_q      <= '0;
            tr_addr_q    <= '0;
            tr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            tr_valid_q   <= tr_valid_d;
            tr_pc_q      <= tr_pc_d;
            tr_addr_q    <= tr_addr_d;
            tr_data_q    <= tr_data_d;
        end
    end

    assign req_ready      = in_idle;
    assign busy           = !in_idle;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign wr_trace_valid = tr_valid_q;
    assign wr_trace_pc    = tr_pc_q;
    assign wr_trace_addr  = tr_addr_q;
    assign wr_trace_data  = tr_data_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed bench for dm_responder with DEPTH_WORDS=16.
// Instance 0 uses LATENCY=2, instance 1 LATENCY=1, instance 2 LATENCY=3.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_dm_responder;

    logic        clk;
    logic        rst_n          [3];
    logic        req_valid      [3];
    logic        req_ready      [3];
    logic        req_we         [3];
    logic [3:0]  req_be         [3];
    logic [31:0] req_addr       [3];
    logic [31:0] req_wdata      [3];
    logic [31:0] req_pc         [3];
    logic        resp_valid     [3];
    logic [31:0] resp_rdata     [3];
    logic        resp_err       [3];
    logic        wr_trace_valid [3];
    logic [31:0] wr_trace_pc    [3];
    logic [31:0] wr_trace_addr  [3];
    logic [31:0] wr_trace_data  [3];
    logic        busy           [3];

    int n_checks = 0;
    int n_fail   = 0;

    dm_responder #(.DEPTH_WORDS(16), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_be(req_be[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_pc(req_pc[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .wr_trace_valid(wr_trace_valid[0]), .wr_trace_pc(wr_trace_pc[0]),
        .wr_trace_addr(wr_trace_addr[0]), .wr_trace_data(wr_trace_data[0]), .busy(busy[0])
    );

    dm_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_be(req_be[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_pc(req_pc[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .wr_trace_valid(wr_trace_valid[1]), .wr_trace_pc(wr_trace_pc[1]),
        .wr_trace_addr(wr_trace_addr[1]), .wr_trace_data(wr_trace_data[1]), .busy(busy[1])
    );

    dm_responder #(.DEPTH_WORDS(16), .LATENCY(3)) u_dut2 (
        .clk(clk), .reset(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_be(req_be[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .req_pc(req_pc[2]), .resp_valid(resp_valid[2]),
        .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]),
        .wr_trace_valid(wr_trace_valid[2]), .wr_trace_pc(wr_trace_pc[2]),
        .wr_trace_addr(wr_trace_addr[2]), .wr_trace_data(wr_trace_data[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request on instance i and collect its response; lat counts edges from
    // the accept edge (1) to the edge after which resp_valid is seen; 0 = no response.
    task automatic run_txn(input int i, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] pc, output int lat,
                           output logic [31:0] rdata, output logic err, output logic tv,
                           output logic [31:0] tpc, output logic [31:0] taddr,
                           output logic [31:0] tdata, output logic nxt_valid);
        int w;
        lat = 0; rdata = '0; err = 1'b0; tv = 1'b0;
        tpc = '0; taddr = '0; tdata = '0; nxt_valid = 1'b0;
        w = 0;
        while (!req_ready[i] && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (!req_ready[i]) return;
        req_valid[i] = 1'b1; req_we[i] = we; req_be[i] = be;
        req_addr[i] = addr; req_wdata[i] = wdata; req_pc[i] = pc;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (resp_valid[i]) begin
                lat = k; rdata = resp_rdata[i]; err = resp_err[i];
                tv = wr_trace_valid[i]; tpc = wr_trace_pc[i];
                taddr = wr_trace_addr[i]; tdata = wr_trace_data[i];
                break;
            end
            @(posedge clk); #1;
        end
        if (lat != 0) begin
            @(posedge clk); #1;
            nxt_valid = resp_valid[i];
        end
    endtask

    task automatic test_reset();
        int k;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_be[i] = '0;
            req_addr[i] = '0; req_wdata[i] = '0; req_pc[i] = '0;
        end
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready[0] !== 1'b0) begin
            n_fail++; $display("FAIL rst_ready got %b want 0", req_ready[0]); end
        n_checks++; if (busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL rst_busy got %b want 1", busy[0]); end
        n_checks++; if (resp_valid[0] !== 1'b0 || wr_trace_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL rst_strobes got %b%b want 00",
                               resp_valid[0], wr_trace_valid[0]); end
        n_checks++; if (resp_rdata[0] !== 32'h0 || wr_trace_data[0] !== 32'h0) begin
            n_fail++; $display("FAIL rst_data got %h/%h want 0",
                               resp_rdata[0], wr_trace_data[0]); end
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1; k++;
            if (req_ready[0]) break;
        end
        n_checks++; if (k !== 16) begin
            n_fail++; $display("FAIL clear_len got %0d want 16", k); end
        @(posedge clk); #1;      // accept edge for the held load of 0x0
        req_valid[0] = 1'b0;
        k = 1;
        while (!resp_valid[0] && k < 20) begin
            @(posedge clk); #1; k++;
        end
        n_checks++; if (k !== 2 || resp_valid[0] !== 1'b1) begin
            n_fail++; $display("FAIL first_lat got %0d want 2", k); end
        n_checks++; if (resp_rdata[0] !== 32'h0 || resp_err[0] !== 1'b0) begin
            n_fail++; $display("FAIL first_load got %h err %b want 0 err 0",
                               resp_rdata[0], resp_err[0]); end
        @(posedge clk); #1;
        n_checks++; if (resp_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL first_strobe got %b want 0", resp_valid[0]); end
    endtask

    task automatic test_store_full();
        int lat; logic [31:0] rd, tpc, ta, td; logic err, tv, nv;
        run_txn(0, 1'b1, 4'hF, 32'h8, 32'hDEADBEEF, 32'h3000, lat, rd, err, tv, tpc, ta, td, nv);
        n_checks++; if (lat !== 2) begin
            n_fail++; $display("FAIL st_lat got %0d want 2", lat); end
        n_checks++; if (err !== 1'b0 || rd !== 32'h0 || nv !== 1'b0) begin
            n_fail++; $display("FAIL st_resp got err %b rd %h nxt %b want 0 0 0", err, rd, nv); end
        n_checks++; if (tv !== 1'b1 || tpc !== 32'h3000 || ta !== 32'h8) begin
            n_fail++; $display("FAIL st_trace got v%b pc %h a %h want 1 3000 8", tv, tpc, ta); end
        n_checks++; if (td !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL st_tdata got %h want deadbeef", td); end
        run_txn(0, 1'b0, 4'h0, 32'h8, 32'h0, 32'h3004, lat, rd, err, tv, tpc, ta, td, nv);
        n_checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0 || tv !== 1'b0) begin
            n_fail++; $display("FAIL ld_full got %h err %b tv %b want deadbeef 0 0", rd, err, tv);
        end
    endtask

    task automatic test_store_partial();
        int lat; logic [31:0] rd, tpc, ta, td; logic err, tv, nv;
        run_txn(0, 1'b1, 4'b0101, 32'h8, 32'h11223344, 32'h3008,
                lat, rd, err, tv, tpc, ta, td, nv);
        n_checks++; if (tv !== 1'b1 || td !== 32'hDE22BE44) begin
            n_fail++; $display("FAIL part_trace got v%b %h want 1 de22be44", tv, td); end
        run_txn(0, 1'b0, 4'h0, 32'h8, 32'h0, 32'h300C, lat, rd, err, tv, tpc, ta, td, nv);
        n_checks++; if (rd !== 32'hDE22BE44) begin
            n_fail++; $display("FAIL part_load got %h want de22be44", rd); end
        run_txn(0, 1'b1, 4'b0000, 32'h8, 32'hFFFFFFFF, 32'h3010,
                lat, rd, err, tv, tpc, ta, td, nv);
        n_checks++; if (tv !== 1'b1 || td !== 32'hDE22BE44 || err !== 1'b0) begin
            n_fail++; $display("FAIL be0_trace got v%b %h err %b want 1 de22be44 0", tv, td, err);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd, tpc, ta, td; logic err, tv, nv;
        run_txn(0, 1'b1, 4'hF, 32'h4, 32'h55AA55AA, 32'h3020, lat, rd, err, tv, tpc, ta, td, nv);
        run_txn(0, 1'b0, 4'h0, 32'h40, 32'h0, 32'h3024, lat, rd, err, tv, tpc, ta, td, nv);
        n_checks++; if (err !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
            n_fail++; $display("FAIL oob_load got err %b rd %h lat %0d want 1 0 2", err, rd, lat);
        end
        run_txn(0, 1'b1, 4'hF, 32'h6, 32'hFFFFFFFF, 32'h3028, lat, rd, err, tv, tpc, ta, td, nv);
        n_checks++; if (err !== 1'b1 || tv !== 1'b0 || rd !== 32'h0) begin
            n_fail++; $display("FAIL mis_store got err %b tv %b rd %h want 1 0 0", err, tv, rd);
        end
        run_txn(0, 1'b0, 4'h0, 32'h4, 32'h0, 32'h302C, lat, rd, err, tv, tpc, ta, td, nv);
        n_checks++; if (rd !== 32'h55AA55AA || err !== 1'b0) begin
            n_fail++; $display("FAIL word1_kept got %h err %b want 55aa55aa 0", rd, err); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] rdy, rv;
        rdy = '0; rv = '0;
        req_we[1] = 1'b0; req_be[1] = '0; req_addr[1] = 32'h0; req_valid[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rdy[c] = req_ready[1];
            @(posedge clk); #1;
            rv[c] = resp_valid[1];
            if (c == 4) req_valid[1] = 1'b0;
        end
        n_checks++; if (rdy !== 6'b010101) begin
            n_fail++; $display("FAIL b2b_accept got %b want 010101", rdy); end
        n_checks++; if (rv !== 6'b010101) begin
            n_fail++; $display("FAIL b2b_resp got %b want 010101", rv); end
    endtask

    task automatic test_reset_midflight();
        int k, seen, lat; logic [31:0] rd, tpc, ta, td; logic err, tv, nv;
        req_we[2] = 1'b1; req_be[2] = 4'hF; req_addr[2] = 32'h4;
        req_wdata[2] = 32'hCAFEF00D; req_pc[2] = 32'h4000; req_valid[2] = 1'b1;
        @(posedge clk); #1;      // accept edge
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        rst_n[2] = 1'b0;
        #1;
        n_checks++; if (busy[2] !== 1'b1 || req_ready[2] !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst got busy %b rdy %b want 1 0", busy[2], req_ready[2]);
        end
        #2 rst_n[2] = 1'b1;
        k = 0; seen = 0;
        while (k < 40) begin
            @(posedge clk); #1; k++;
            if (resp_valid[2] || wr_trace_valid[2]) seen++;
            if (req_ready[2]) break;
        end
        n_checks++; if (seen !== 0) begin
            n_fail++; $display("FAIL mid_suppress got %0d strobes want 0", seen); end
        n_checks++; if (k !== 16) begin
            n_fail++; $display("FAIL mid_clear got %0d want 16", k); end
        run_txn(2, 1'b0, 4'h0, 32'h4, 32'h0, 32'h4004, lat, rd, err, tv, tpc, ta, td, nv);
        n_checks++; if (rd !== 32'h0 || err !== 1'b0 || lat !== 3) begin
            n_fail++; $display("FAIL mid_load got %h err %b lat %0d want 0 0 3", rd, err, lat); end
    endtask

    initial begin
        test_reset();
        test_store_full();
        test_store_partial();
        test_errors();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the data-memory port that the five-stage pipeline drives from its M stage.
- Accepts one word-aligned load or store request at a time over a valid/ready handshake and returns a response after a fixed, configurable latency.
- Emits a per-store trace record, so the pipeline can be verified against a multi-cycle memory and later extended with cycle-level stalls.

Parameters:
- DEPTH_WORDS, 3072: number of 32-bit words in the array; word index = req_addr[31:2].
- LATENCY, 2: cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_be  input  4  byte enables for stores; bit i covers bits [8i+7:8i]; ignored for loads.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_pc  input  32  PC of the issuing instruction; used for the trace only.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  qualifies resp_valid: address out of range or misaligned.
- wr_trace_valid  output  1  one-cycle strobe on a committed store.
- wr_trace_pc  output  32  req_pc of the committed store.
- wr_trace_addr  output  32  word-aligned byte address ({idx,2'b00}).
- wr_trace_data  output  32  full merged word after the store.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: CLEAR, IDLE, WAIT, RESP.
- Reset (reset=0, asynchronous):
  - State goes to CLEAR; clear index 0.
  - req_ready, resp_valid, resp_err and wr_trace_valid are 0; all data outputs are 0; busy is 1.
  - Any pending request is dropped and no write occurs.
- CLEAR:
  - Writes 0 to word[clr_idx] every cycle; clr_idx increments.
  - After writing word DEPTH_WORDS-1, goes to IDLE.
  - Duration: exactly DEPTH_WORDS cycles after reset release.
- IDLE:
  - req_ready=1, combinationally from state only; it does not depend on req_valid.
  - On req_valid&&req_ready, latch we/be/addr/wdata/pc.
  - Load count register with LATENCY-1.
  - Next state: RESP if LATENCY==1, else WAIT.
- WAIT: req_ready=0; decrement count; go to RESP when count reaches 1.
- RESP:
  - Outputs are registered in the transition into RESP and valid during that one cycle; resp_valid=1 for exactly one cycle.
  - Next state is IDLE, so back-to-back accepts are spaced LATENCY+1 cycles apart.
- Timing: request accepted at edge T gives resp_valid high in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles later.
- No back-pressure on the response; the requester must consume it.
- Error condition: addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS.
  - resp_err=1, resp_rdata=0.
  - A store is not committed and produces no trace.
- Load: resp_rdata = word[idx].
- Store commit:
  - Happens on the edge entering RESP.
  - Merged word: new byte i = be[i] ? wdata byte i : old byte i.
  - wr_trace_valid=1 in RESP with the merged word.
- Store with be=4'b0000: no change to memory; trace still fires with the unchanged word; resp_err=0.
- Reset asserted in WAIT or RESP: response is suppressed and the store is not committed; CLEAR restarts from index 0.
- Memory is a single write port (CLEAR or commit, never both) and one combinational read by latched index.

Decomposition:
- Shared package holds the state encoding (CLEAR/IDLE/WAIT/RESP) and byte-lane width constants (4 lanes, 8 bits each).
- The byte-merge function lives there too, for reuse by later sb/sh support.
- Sub-module dm_array: the storage array with one write port (index, data, enable) and one read index.
- The FSM, counter and trace registers stay in dm_responder.

Test Plan (DEPTH_WORDS=16 unless stated):
- Release reset, hold req_valid=1 -> req_ready stays 0 for 16 cycles, then 1; a load from 0x0 returns 0x00000000, err=0.
- LATENCY=2: store 0x0000_0008 data 0xDEADBEEF be=4'hF pc=0x3000 -> resp_valid exactly 2 cycles after accept; trace shows pc=0x3000, addr=0x8, data=0xDEADBEEF. A following load of 0x8 returns 0xDEADBEEF.
- After the previous case, store 0x8 data 0x11223344 be=4'b0101 -> trace data 0xDE22BE44; a load returns the same value.
- Load 0x40 (index 16) -> resp_err=1, rdata=0. Store 0x6 -> resp_err=1, no trace, and word 1 is unchanged.
- LATENCY=1: three back-to-back loads with req_valid held -> accepts on cycles 0, 2 and 4; responses on cycles 1, 3 and 5.
- Store accepted with LATENCY=3, reset pulsed one cycle later -> no resp_valid and no trace; after CLEAR, the target word reads 0.
